matmul_tile_scheduler: RTL
==========================

MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL use parameters (name, default, meaning): AWIDTH, 11, BRAM address width.
REQ-002 SHALL use parameters: MASK_WIDTH, 8, tile edge size and mask width.
REQ-003 SHALL use parameters: ADDR_STRIDE_WIDTH, 8, stride width.
REQ-004 Ports (name, direction, width, meaning), clock and reset first: clk, in, 1, clock.
REQ-005 resetn, in, 1, reset; synchronous, active-low.
REQ-006 start, in, 1, launches a job from IDLE; clear_done, in, 1, returns from DONE to IDLE.
REQ-007 base_a, base_b, base_c, in, AWIDTH each, tile (0,0) addresses.
REQ-008 step_a_m, step_b_n, step_c_m, step_c_n, in, AWIDTH each, address increment per tile row or column.
REQ-009 stride_a, stride_b, stride_c, in, ADDR_STRIDE_WIDTH each, passed through unchanged.
REQ-010 dim_m, dim_n, in, 7 each, matrix rows and columns (0..64); dim_k, in, 4, inner dimension (0..8).
REQ-011 mm_start, out, 1; mm_done, in, 1: handshake to the 8x8 systolic core.
REQ-012 address_mat_a, address_mat_b, address_mat_c, out, AWIDTH each, current tile addresses.
REQ-013 address_stride_a/b/c, out, ADDR_STRIDE_WIDTH each; validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols, out, MASK_WIDTH each.
REQ-014 busy, out, 1; done, out, 1; err, out, 1; tiles_done, out, 7, completed tile count.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-016 IDLE with start=1 SHALL latch all configuration inputs, clear mi, nj and tiles_done, and enter ISSUE on the next cycle; the latched copy SHALL be used until DONE.
REQ-017 If dim_m, dim_n or dim_k is 0, or dim_k > 8, at start, the block SHALL go directly to DONE with err=1 and SHALL NOT assert mm_start.
REQ-018 ISSUE SHALL drive tile outputs, assert mm_start, and enter WAIT; mm_start SHALL remain 1 throughout WAIT.
REQ-019 Tile addresses: address_mat_a = base_a + mi*step_a_m; address_mat_b = base_b + nj*step_b_n; address_mat_c = base_c + mi*step_c_m + nj*step_c_n; all modulo 2^AWIDTH (wrap, no error).
REQ-020 Masks: rows = min(8, dim_m - 8*mi); cols = min(8, dim_n - 8*nj); validity mask = (1<<count)-1, all ones for count 8; validity_mask_a_cols_b_rows = (1<<dim_k)-1.
REQ-021 WAIT with mm_done=1 SHALL deassert mm_start on the next edge, increment tiles_done, and enter DRAIN.
REQ-022 DRAIN SHALL hold until mm_done=0; then, if this was the last tile, enter DONE, else advance the tile and enter ISSUE.
REQ-023 Tile order SHALL be row-major: nj increments first; at nj = ceil(dim_n/8)-1, nj wraps to 0 and mi increments; the last tile is (ceil(dim_m/8)-1, ceil(dim_n/8)-1).
REQ-024 busy SHALL be 1 in ISSUE, WAIT and DRAIN; done SHALL be 1 only in DONE.
REQ-025 DONE SHALL hold outputs until clear_done=1, then enter IDLE next cycle, clearing err; start in DONE SHALL be ignored.
REQ-026 start during busy SHALL be ignored; mm_done outside WAIT/DRAIN SHALL be ignored.
REQ-027 All outputs SHALL be registered; the latency from start sampled in IDLE to mm_start=1 SHALL be 2 cycles.

Reset
REQ-028 resetn=0 at any clock edge, including mid-job, SHALL force IDLE and set mm_start, busy, done, err, tiles_done, addresses and masks to 0, discarding the job.

Structure
REQ-029 State encoding, tile edge 8 and dimension widths SHALL live in a shared package with the matmul constants.
REQ-030 One sub-module, tile_mask_gen (count -> thermometer mask), is natural; the address arithmetic SHALL use incremental adders, not multipliers.

Verification
REQ-031 dim 8x8x8, base_a=0x000 -> one tile, addresses 0/base_b/base_c, all masks 0xFF, done=1, tiles_done=1.
REQ-032 dim_m=20, dim_n=12, dim_k=5 -> 6 tiles in order (0,0),(0,1),(1,0)..(2,1); last row mask 0x0F, last column mask 0x0F, k mask 0x1F.
REQ-033 mm_done held high 3 cycles after a tile -> no next mm_start until mm_done=0; tiles_done increments once.
REQ-034 dim_n=0 -> done=1, err=1 within 2 cycles, mm_start never asserted; clear_done -> IDLE, err=0.
REQ-035 resetn=0 in WAIT of tile 3 -> all outputs 0 next cycle; new start runs from tile (0,0).
REQ-036 base_c=0x7F0, step_c_n=0x020 -> second tile address_mat_c=0x010 (wrap).

Source files
------------

// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the matmul tile scheduler.
// The systolic core works on fixed 8x8 tiles; the dimension widths below
// cover matrices of up to 64x64 with an inner dimension of up to 8.
package matmul_tile_scheduler_pkg;

    // Tile geometry of the systolic core
    localparam int TILE_EDGE    = 8;

    // Dimension input widths
    localparam int DIM_MN_W     = 7;
    localparam int DIM_K_W      = 4;

    // Completed-tile counter width (64 tiles max)
    localparam int TILES_DONE_W = 7;

    // Typed constants so comparisons and subtractions stay width-matched
    localparam logic [DIM_MN_W-1:0] TILE_EDGE_MN = 7'd8;
    localparam logic [DIM_K_W-1:0]  MAX_DIM_K    = 4'd8;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // A job is rejected when any dimension is empty or the inner
    // dimension exceeds what the core can accumulate in one pass.
    function automatic logic config_invalid(
        input logic [DIM_MN_W-1:0] m,
        input logic [DIM_MN_W-1:0] n,
        input logic [DIM_K_W-1:0]  k
    );
        return (m == '0) || (n == '0) || (k == '0) || (k > MAX_DIM_K);
    endfunction

    // A dimension remainder of TILE_EDGE or less means this is the final
    // tile along that axis.
    function automatic logic is_last_tile(input logic [DIM_MN_W-1:0] remaining);
        return remaining <= TILE_EDGE_MN;
    endfunction

endpackage

// File: rtl/matmul_tile_scheduler_tile_mask_gen.sv
// Converts an element count into a thermometer validity mask.
// Bit i is set when count > i, so any count at or above MASK_WIDTH
// saturates to all ones; that gives min(MASK_WIDTH, count) for free.
module tile_mask_gen #(
    parameter int COUNT_W    = 7,
    parameter int MASK_WIDTH = 8
) (
    input  logic [COUNT_W-1:0]    count,
    output logic [MASK_WIDTH-1:0] mask
);

    // Per-bit comparison against the lane index builds the thermometer code
    always_comb begin
        mask = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            mask[i] = (int'(count) > i);
        end
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks an M x N output matrix in 8x8 tiles (row-major), handing each tile's
// BRAM addresses and validity masks to the systolic core and waiting for
// its mm_start/mm_done handshake. Tile addresses are stepped with adders
// as the walk advances, so no multipliers are needed. Remaining row and
// column counts double as the tile position and feed the mask generators.
module matmul_tile_scheduler
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int AWIDTH            = 11,
    parameter int MASK_WIDTH        = 8,
    parameter int ADDR_STRIDE_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         clear_done,
    input  logic [AWIDTH-1:0]            base_a,
    input  logic [AWIDTH-1:0]            base_b,
    input  logic [AWIDTH-1:0]            base_c,
    input  logic [AWIDTH-1:0]            step_a_m,
    input  logic [AWIDTH-1:0]            step_b_n,
    input  logic [AWIDTH-1:0]            step_c_m,
    input  logic [AWIDTH-1:0]            step_c_n,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_a,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_c,
    input  logic [DIM_MN_W-1:0]          dim_m,
    input  logic [DIM_MN_W-1:0]          dim_n,
    input  logic [DIM_K_W-1:0]           dim_k,
    output logic                         mm_start,
    input  logic                         mm_done,
    output logic [AWIDTH-1:0]            address_mat_a,
    output logic [AWIDTH-1:0]            address_mat_b,
    output logic [AWIDTH-1:0]            address_mat_c,
    output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a,
    output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b,
    output logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c,
    output logic [MASK_WIDTH-1:0]        validity_mask_a_rows,
    output logic [MASK_WIDTH-1:0]        validity_mask_a_cols_b_rows,
    output logic [MASK_WIDTH-1:0]        validity_mask_b_cols,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [TILES_DONE_W-1:0]      tiles_done
);

    sched_state_t state;

    // Job configuration held for the whole job
    logic [AWIDTH-1:0]            base_b_q;
    logic [AWIDTH-1:0]            step_a_m_q;
    logic [AWIDTH-1:0]            step_b_n_q;
    logic [AWIDTH-1:0]            step_c_m_q;
    logic [AWIDTH-1:0]            step_c_n_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_a_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_b_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_c_q;
    logic [DIM_MN_W-1:0]          dim_n_q;
    logic [DIM_K_W-1:0]           dim_k_q;

    // Running tile position: addresses of the current tile row/column and
    // the elements still left in each direction (dim - 8*index)
    logic [AWIDTH-1:0]            addr_a_row;
    logic [AWIDTH-1:0]            addr_c_row;
    logic [AWIDTH-1:0]            addr_b_col;
    logic [AWIDTH-1:0]            addr_c_cur;
    logic [DIM_MN_W-1:0]          rows_left;
    logic [DIM_MN_W-1:0]          cols_left;

    logic                         last_row;
    logic                         last_col;
    logic [MASK_WIDTH-1:0]        row_mask;
    logic [MASK_WIDTH-1:0]        col_mask;
    logic [MASK_WIDTH-1:0]        k_mask;

    // End-of-axis detection for the row-major walk
    always_comb begin
        last_row = is_last_tile(rows_left);
        last_col = is_last_tile(cols_left);
    end

    tile_mask_gen #(
        .COUNT_W    (DIM_MN_W),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_row_mask (
        .count (rows_left),
        .mask  (row_mask)
    );

    tile_mask_gen #(
        .COUNT_W    (DIM_MN_W),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_col_mask (
        .count (cols_left),
        .mask  (col_mask)
    );

    tile_mask_gen #(
        .COUNT_W    (DIM_K_W),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_k_mask (
        .count (dim_k_q),
        .mask  (k_mask)
    );

    // Scheduler FSM: latches the job, issues tiles, tracks the core
    // handshake and steps the tile position; all outputs are registered here
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                       <= IDLE;
            base_b_q                    <= '0;
            step_a_m_q                  <= '0;
            step_b_n_q                  <= '0;
            step_c_m_q                  <= '0;
            step_c_n_q                  <= '0;
            stride_a_q                  <= '0;
            stride_b_q                  <= '0;
            stride_c_q                  <= '0;
            dim_n_q                     <= '0;
            dim_k_q                     <= '0;
            addr_a_row                  <= '0;
            addr_c_row                  <= '0;
            addr_b_col                  <= '0;
            addr_c_cur                  <= '0;
            rows_left                   <= '0;
            cols_left                   <= '0;
            mm_start                    <= 1'b0;
            address_mat_a               <= '0;
            address_mat_b               <= '0;
            address_mat_c               <= '0;
            address_stride_a            <= '0;
            address_stride_b            <= '0;
            address_stride_c            <= '0;
            validity_mask_a_rows        <= '0;
            validity_mask_a_cols_b_rows <= '0;
            validity_mask_b_cols        <= '0;
            busy                        <= 1'b0;
            done                        <= 1'b0;
            err                         <= 1'b0;
            tiles_done                  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_b_q   <= base_b;
                        step_a_m_q <= step_a_m;
                        step_b_n_q <= step_b_n;
                        step_c_m_q <= step_c_m;
                        step_c_n_q <= step_c_n;
                        stride_a_q <= stride_a;
                        stride_b_q <= stride_b;
                        stride_c_q <= stride_c;
                        dim_n_q    <= dim_n;
                        dim_k_q    <= dim_k;
                        addr_a_row <= base_a;
                        addr_c_row <= base_c;
                        addr_b_col <= base_b;
                        addr_c_cur <= base_c;
                        rows_left  <= dim_m;
                        cols_left  <= dim_n;
                        tiles_done <= '0;
                        if (config_invalid(dim_m, dim_n, dim_k)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    address_mat_a               <= addr_a_row;
                    address_mat_b               <= addr_b_col;
                    address_mat_c               <= addr_c_cur;
                    address_stride_a            <= stride_a_q;
                    address_stride_b            <= stride_b_q;
                    address_stride_c            <= stride_c_q;
                    validity_mask_a_rows        <= row_mask;
                    validity_mask_b_cols        <= col_mask;
                    validity_mask_a_cols_b_rows <= k_mask;
                    mm_start                    <= 1'b1;
                    state                       <= WAIT;
                end

                WAIT: begin
                    if (mm_done) begin
                        mm_start   <= 1'b0;
                        tiles_done <= tiles_done + 7'd1;
                        state      <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (!mm_done) begin
                        if (last_row && last_col) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            if (last_col) begin
                                cols_left  <= dim_n_q;
                                rows_left  <= rows_left - TILE_EDGE_MN;
                                addr_a_row <= addr_a_row + step_a_m_q;
                                addr_c_row <= addr_c_row + step_c_m_q;
                                addr_c_cur <= addr_c_row + step_c_m_q;
                                addr_b_col <= base_b_q;
                            end else begin
                                cols_left  <= cols_left - TILE_EDGE_MN;
                                addr_b_col <= addr_b_col + step_b_n_q;
                                addr_c_cur <= addr_c_cur + step_c_n_q;
                            end
                        end
                    end
                end

                DONE: begin
                    if (clear_done) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
